// File: rtl/rf_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Widths below match the 8x16 register file.
package rf_pkg;

  localparam int unsigned RF_DW    = 16;
  localparam int unsigned RF_AW    = 3;
  localparam int unsigned NREQ_MAX = 4;

  typedef struct packed {
    logic [RF_AW-1:0] sel;
    logic [RF_DW-1:0] data;
  } wr_req_t;

  typedef enum logic {
    RQ_IDLE = 1'b0,
    RQ_WAIT = 1'b1
  } rq_state_t;

endpackage

// File: rtl/rf_wr_arb_if.sv
// Requester-side and register-file-side signals of the write-port arbiter.
// The arbiter takes the slave modport; the requesters and the register file take the master modport.
interface rf_wr_arb_if
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = RF_DW,
  parameter int unsigned AW   = RF_AW
);
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_sel;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic [AW-1:0]        rf_writeregsel;
  logic [DW-1:0]        rf_writedata;
  logic                 rf_write;
  logic                 err;

  modport master (
    output hold, req_valid, req_sel, req_data,
    input  req_ready, rf_writeregsel, rf_writedata, rf_write, err
  );

  modport slave (
    input  hold, req_valid, req_sel, req_data,
    output req_ready, rf_writeregsel, rf_writedata, rf_write, err
  );
endinterface

// File: rtl/rr_arb.sv
// Round-robin picker: scans ptr+1, ptr+2, ... modulo NREQ and grants the first valid request.
// A ptr of NREQ-1 gives plain lowest-index-first priority.
module rr_arb #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            hold,
  output logic [NREQ-1:0] gnt_c
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PW'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    if (hold) gnt_c = '0;
  end

endmodule

// File: rtl/rf_wr_arb.sv
// Arbitrates NREQ writers onto the single register-file write port, registering the winner.
// Define RFARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module rf_wr_arb
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned DW   = RF_DW,
  parameter int unsigned AW   = RF_AW
) (
  input  logic        clk,
  input  logic        rst,
  rf_wr_arb_if.slave  bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win_idx;
  wr_req_t         win_req;
  logic            accept;
  logic            viol;
  wr_req_t         cur   [NREQ];
  wr_req_t         cap   [NREQ];
  wr_req_t         cap_n [NREQ];
  rq_state_t       st    [NREQ];
  rq_state_t       st_n  [NREQ];

`ifdef RFARB_FIXED_PRIO_EN
  assign ptr = PW'(NREQ - 1);
`else
  logic [PW-1:0] ptr_q;

  // Last winner; the next scan starts one past it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        ptr_q <= PW'(NREQ - 1);
    else if (accept) ptr_q <= win_idx;
  end

  assign ptr = ptr_q;
`endif

  rr_arb #(.NREQ(NREQ), .PW(PW)) u_rr_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .hold  (bus.hold),
    .gnt_c (gnt)
  );

  assign bus.req_ready = gnt;
  assign accept        = |gnt;

  // Unpack per-requester payloads and select the granted one.
  always_comb begin
    win_idx = '0;
    win_req = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cur[i].sel  = RF_AW'(bus.req_sel[i*AW +: AW]);
      cur[i].data = RF_DW'(bus.req_data[i*DW +: DW]);
      if (gnt[i]) begin
        win_idx = PW'(i);
        win_req = cur[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rf_write       <= 1'b0;
      bus.rf_writeregsel <= '0;
      bus.rf_writedata   <= '0;
    end else if (accept) begin
      bus.rf_write       <= 1'b1;
      bus.rf_writeregsel <= AW'(win_req.sel);
      bus.rf_writedata   <= DW'(win_req.data);
    end else begin
      bus.rf_write       <= 1'b0;
    end
  end

  // Per-requester waiting tracker; a waiting request must hold valid, sel and data.
  always_comb begin
    viol = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      st_n[i]  = st[i];
      cap_n[i] = cap[i];
      case (st[i])
        RQ_IDLE: begin
          if (bus.req_valid[i] && !gnt[i]) begin
            st_n[i]  = RQ_WAIT;
            cap_n[i] = cur[i];
          end
        end
        RQ_WAIT: begin
          if (!bus.req_valid[i] || (cur[i] != cap[i])) begin
            viol    = 1'b1;
            st_n[i] = RQ_IDLE;
          end else if (gnt[i]) begin
            st_n[i] = RQ_IDLE;
          end
        end
        default: st_n[i] = RQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        st[i]  <= RQ_IDLE;
        cap[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        st[i]  <= st_n[i];
        cap[i] <= cap_n[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      bus.err <= 1'b0;
    else if (viol) bus.err <= 1'b1;
  end

endmodule

// File: tb/tb_rf_wr_arb.sv
// Self-checking bench for rf_wr_arb (NREQ=2): directed vector table, hand-written
// reset/error sequences, and randomized legal traffic against a behavioural model.
module tb_rf_wr_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  rf_wr_arb_if #(.NREQ(2), .DW(16), .AW(3)) bus ();

  rf_wr_arb #(.NREQ(2), .DW(16), .AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        do_rst;
    logic        hold;
    logic [1:0]  v;
    logic [5:0]  sel;
    logic [31:0] data;
    logic [1:0]  ready;
    logic        wr;
    logic [2:0]  wsel;
    logic [15:0] wdata;
    logic        err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic rs, input logic h, input logic [1:0] v, input logic [5:0] s,
                     input logic [31:0] d, input logic [1:0] rdy, input logic w,
                     input logic [2:0] ws, input logic [15:0] wd, input logic e);
    vec_t r;
    r.do_rst = rs; r.hold = h; r.v = v; r.sel = s; r.data = d;
    r.ready = rdy; r.wr = w; r.wsel = ws; r.wdata = wd; r.err = e;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic h, input logic [1:0] v, input logic [5:0] s, input logic [31:0] d);
    bus.hold      = h;
    bus.req_valid = v;
    bus.req_sel   = s;
    bus.req_data  = d;
  endtask

  // Leaves the bench at posedge+1 with reset released.
  task automatic do_reset();
    drive(1'b0, 2'b00, 6'h0, 32'h0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rf_write", 32'(bus.rf_write), 32'h0);
    chk("reset_regsel", 32'(bus.rf_writeregsel), 32'h0);
    chk("reset_wdata", 32'(bus.rf_writedata), 32'h0);
    chk("reset_err", 32'(bus.err), 32'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model state for the random phase.
  int          last;
  logic        m_wr;
  logic [2:0]  m_sel;
  logic [15:0] m_data;
  logic [2:0]  rs [2];
  logic [15:0] rd [2];
  logic        pend [2];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 2'b00, 6'h0, 32'h0);

    // Single request after reset.
    add(1, 0, 2'b01, {3'd0, 3'd3}, {16'h0, 16'hBEEF}, 2'b01, 0, 3'd0, 16'h0,    0);
    add(0, 0, 2'b00, {3'd0, 3'd3}, {16'h0, 16'hBEEF}, 2'b00, 1, 3'd3, 16'hBEEF, 0);
    add(0, 0, 2'b00, {3'd0, 3'd3}, {16'h0, 16'hBEEF}, 2'b00, 0, 3'd3, 16'hBEEF, 0);
    // Both requesters valid: alternating grants, continuous writes.
    add(1, 0, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b01, 0, 3'd0, 16'h0,    0);
    add(0, 0, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b10, 1, 3'd1, 16'h1111, 0);
    add(0, 0, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b01, 1, 3'd2, 16'h2222, 0);
    add(0, 0, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b10, 1, 3'd1, 16'h1111, 0);
    add(0, 0, 2'b01, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b01, 1, 3'd2, 16'h2222, 0);
    // Hold for three cycles; last winner is requester 0, so requester 1 goes next.
    add(0, 1, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b00, 1, 3'd1, 16'h1111, 0);
    add(0, 1, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b00, 0, 3'd1, 16'h1111, 0);
    add(0, 1, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b00, 0, 3'd1, 16'h1111, 0);
    add(0, 0, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b10, 0, 3'd1, 16'h1111, 0);
    add(0, 0, 2'b01, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b01, 1, 3'd2, 16'h2222, 0);
    add(0, 0, 2'b00, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b00, 1, 3'd1, 16'h1111, 0);
    add(0, 0, 2'b00, {3'd2, 3'd1}, {16'h2222, 16'h1111}, 2'b00, 0, 3'd1, 16'h1111, 0);
    // Same-register collision: serialized, second winner's data lands last.
    add(1, 0, 2'b11, {3'd5, 3'd5}, {16'h000B, 16'h000A}, 2'b01, 0, 3'd0, 16'h0,    0);
    add(0, 0, 2'b10, {3'd5, 3'd5}, {16'h000B, 16'h000A}, 2'b10, 1, 3'd5, 16'h000A, 0);
    add(0, 0, 2'b00, {3'd5, 3'd5}, {16'h000B, 16'h000A}, 2'b00, 1, 3'd5, 16'h000B, 0);
    add(0, 0, 2'b00, {3'd5, 3'd5}, {16'h000B, 16'h000A}, 2'b00, 0, 3'd5, 16'h000B, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].do_rst) do_reset();
      drive(tbl[i].hold, tbl[i].v, tbl[i].sel, tbl[i].data);
      @(negedge clk);
      chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
      chk($sformatf("vec%0d_write", i), 32'(bus.rf_write), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_regsel", i), 32'(bus.rf_writeregsel), 32'(tbl[i].wsel));
      chk($sformatf("vec%0d_wdata", i), 32'(bus.rf_writedata), 32'(tbl[i].wdata));
      chk($sformatf("vec%0d_err", i), 32'(bus.err), 32'(tbl[i].err));
      next_cycle();
    end

    // Requester 1 waits under hold, then drops valid: sticky err.
    do_reset();
    drive(1'b1, 2'b10, {3'd4, 3'd0}, {16'h1234, 16'h0});
    @(negedge clk);
    chk("err_hold_ready", 32'(bus.req_ready), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("err_before_drop", 32'(bus.err), 32'h0);
    next_cycle();
    drive(1'b0, 2'b00, {3'd4, 3'd0}, {16'h1234, 16'h0});
    @(negedge clk);
    chk("err_not_yet", 32'(bus.err), 32'h0);
    next_cycle();
    @(negedge clk);
    chk("err_set", 32'(bus.err), 32'h1);
    next_cycle();
    drive(1'b0, 2'b01, {3'd0, 3'd1}, {16'h0, 16'h5555});
    @(negedge clk);
    chk("err_legal_ready", 32'(bus.req_ready), 32'h1);
    chk("err_sticky1", 32'(bus.err), 32'h1);
    next_cycle();
    drive(1'b0, 2'b00, {3'd0, 3'd1}, {16'h0, 16'h5555});
    @(negedge clk);
    chk("err_legal_write", 32'(bus.rf_write), 32'h1);
    chk("err_legal_wdata", 32'(bus.rf_writedata), 32'h5555);
    chk("err_sticky2", 32'(bus.err), 32'h1);
    next_cycle();

    // Asynchronous reset between acceptance and the write cycle.
    do_reset();
    drive(1'b0, 2'b01, {3'd0, 3'd6}, {16'h0, 16'hCAFE});
    @(negedge clk);
    chk("arst_ready", 32'(bus.req_ready), 32'h1);
    next_cycle();
    drive(1'b0, 2'b00, {3'd0, 3'd6}, {16'h0, 16'hCAFE});
    chk("arst_write_pre", 32'(bus.rf_write), 32'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_write_drop", 32'(bus.rf_write), 32'h0);
    chk("arst_wdata", 32'(bus.rf_writedata), 32'h0);
    chk("arst_err", 32'(bus.err), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    next_cycle();
    drive(1'b0, 2'b11, {3'd2, 3'd1}, {16'h2222, 16'h1111});
    @(negedge clk);
    chk("arst_prio0", 32'(bus.req_ready), 32'h1);
    next_cycle();
    drive(1'b0, 2'b10, {3'd2, 3'd1}, {16'h2222, 16'h1111});
    next_cycle();

    // Randomized legal traffic against the behavioural model.
    do_reset();
    last = 1; m_wr = 1'b0; m_sel = 3'd0; m_data = 16'h0;
    for (int j = 0; j < 2; j++) begin
      pend[j] = 1'b0; rs[j] = 3'd0; rd[j] = 16'h0;
    end
    for (int c = 0; c < 400; c++) begin
      logic [1:0] v;
      logic       h;
      int         win;
      logic [1:0] exp_rdy;
      for (int j = 0; j < 2; j++) begin
        if (pend[j]) begin
          v[j] = 1'b1;
        end else begin
          v[j]  = ($urandom_range(0, 2) != 0);
          rs[j] = 3'($urandom);
          rd[j] = 16'($urandom);
        end
      end
      h = ($urandom_range(0, 4) == 0);
      win = -1;
      if (!h) begin
        for (int k = 1; k <= 2; k++) begin
          int j;
          j = (last + k) % 2;
          if (win < 0 && v[j]) win = j;
        end
      end
      exp_rdy = 2'b00;
      if (win >= 0) exp_rdy[win] = 1'b1;
      drive(h, v, {rs[1], rs[0]}, {rd[1], rd[0]});
      @(negedge clk);
      chk($sformatf("rand%0d_ready", c), 32'(bus.req_ready), 32'(exp_rdy));
      chk($sformatf("rand%0d_write", c), 32'(bus.rf_write), 32'(m_wr));
      chk($sformatf("rand%0d_regsel", c), 32'(bus.rf_writeregsel), 32'(m_sel));
      chk($sformatf("rand%0d_wdata", c), 32'(bus.rf_writedata), 32'(m_data));
      chk($sformatf("rand%0d_err", c), 32'(bus.err), 32'h0);
      next_cycle();
      if (win >= 0) begin
        m_wr = 1'b1; m_sel = rs[win]; m_data = rd[win]; last = win;
      end else begin
        m_wr = 1'b0;
      end
      for (int j = 0; j < 2; j++) pend[j] = v[j] && (win != j);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
